// File: rtl/kernel_pixel_sram.sv
// kernel_pixel_sram: banked single-port SRAM with registered valid/ready read port
// and a burst engine that streams consecutive words of one bank under backpressure.
module kernel_pixel_sram #(
    parameter int DATA_W  = 8,
    parameter int KERN_AW = 4,
    parameter int PIX_AW  = 6,
    parameter int BURST_W = 6
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_cs,
    input  logic               i_we,
    input  logic               i_rd,
    input  logic [KERN_AW-1:0] i_kern_addr,
    input  logic [PIX_AW-1:0]  i_pix_addr,
    input  logic [DATA_W-1:0]  i_data_in,
    input  logic               i_burst_start,
    input  logic [BURST_W-1:0] i_burst_len,
    input  logic               i_out_ready,
    output logic [DATA_W-1:0]  o_data_out,
    output logic               o_data_valid,
    output logic               o_burst_busy,
    output logic               o_burst_done
);
    localparam int AW = KERN_AW + PIX_AW;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t             r_state, w_next;
    logic [DATA_W-1:0]  r_mem [2**AW];
    logic [DATA_W-1:0]  r_data;
    logic               r_valid;
    logic [KERN_AW-1:0] r_bank, w_bank_nx;
    logic [PIX_AW-1:0]  r_ptr, w_ptr_nx;
    logic [BURST_W-1:0] r_rem, w_rem_nx;
    logic               w_slot_free, w_rd_issue, w_wr;
    logic [AW-1:0]      w_rd_addr;

    assign w_slot_free = !r_valid || i_out_ready;

    always_comb begin
        w_next     = r_state;
        w_bank_nx  = r_bank;
        w_ptr_nx   = r_ptr;
        w_rem_nx   = r_rem;
        w_rd_issue = 1'b0;
        w_wr       = 1'b0;
        w_rd_addr  = {i_kern_addr, i_pix_addr};
        case (r_state)
            IDLE: if (i_cs) begin
                if (i_we) w_wr = 1'b1;
                else if (i_burst_start) begin
                    if (i_burst_len == '0) w_next = DONE;
                    else begin
                        // first beat is issued straight away when the slot allows it
                        w_bank_nx  = i_kern_addr;
                        w_rd_issue = w_slot_free;
                        w_ptr_nx   = i_pix_addr + PIX_AW'(w_slot_free);
                        w_rem_nx   = i_burst_len - BURST_W'(w_slot_free);
                        w_next     = (w_slot_free && i_burst_len == BURST_W'(1)) ? DRAIN : RUN;
                    end
                end
                else if (i_rd) w_rd_issue = w_slot_free;
            end
            RUN: begin
                w_rd_addr = {r_bank, r_ptr};
                if (w_slot_free) begin
                    w_rd_issue = 1'b1;
                    w_ptr_nx   = r_ptr + PIX_AW'(1);
                    w_rem_nx   = r_rem - BURST_W'(1);
                    if (r_rem == BURST_W'(1)) w_next = DRAIN;
                end
            end
            DRAIN: if (r_valid && i_out_ready) w_next = DONE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= IDLE;
            r_bank  <= '0;
            r_ptr   <= '0;
            r_rem   <= '0;
            r_data  <= '0;
            r_valid <= 1'b0;
        end else begin
            r_state <= w_next;
            r_bank  <= w_bank_nx;
            r_ptr   <= w_ptr_nx;
            r_rem   <= w_rem_nx;
            if (w_rd_issue) begin
                r_data  <= r_mem[w_rd_addr];
                r_valid <= 1'b1;
            end else if (i_out_ready) r_valid <= 1'b0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_wr) r_mem[{i_kern_addr, i_pix_addr}] <= i_data_in;
    end

    assign o_data_out   = r_data;
    assign o_data_valid = r_valid;
    assign o_burst_busy = (r_state == RUN) || (r_state == DRAIN);
    assign o_burst_done = (r_state == DONE);
endmodule
